// File: rtl/lvt_bram_arbiter.sv
// Round-robin arbiter sharing both ports of a true-dual-port BRAM (16x32, read latency RD_LAT) among NREQ requesters.
// Optional feature macro: BRAM_ARB_COLLISION_EN (defer port B when it would collide with a write to the same address).
module lvt_bram_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rvalid,
  output logic [NREQ*DATA_W-1:0]   rdata,
  output logic                     ena,
  output logic                     wea,
  output logic [ADDR_W-1:0]        addra,
  output logic [DATA_W-1:0]        dina,
  input  logic [DATA_W-1:0]        douta,
  output logic                     enb,
  output logic                     web,
  output logic [ADDR_W-1:0]        addrb,
  output logic [DATA_W-1:0]        dinb,
  input  logic [DATA_W-1:0]        doutb
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef struct packed {
    logic             vld;
    logic [PTR_W-1:0] idx;
  } tag_t;

  logic [ADDR_W-1:0] w_addr  [NREQ];
  logic [DATA_W-1:0] w_wdata [NREQ];

  logic [PTR_W-1:0]  r_ptr;
  logic [PTR_W-1:0]  w_scan;
  logic [PTR_W-1:0]  w_p_idx;
  logic [PTR_W-1:0]  w_q_idx;
  logic [PTR_W-1:0]  w_last;
  logic [PTR_W-1:0]  w_ptr_nxt;
  logic              w_p_vld;
  logic              w_q_vld;
  logic              w_q_gnt;
  logic              w_coll;
  logic [NREQ-1:0]   w_gnt;

  logic              r_ena;
  logic              r_wea;
  logic [ADDR_W-1:0] r_addra;
  logic [DATA_W-1:0] r_dina;
  logic              r_enb;
  logic              r_web;
  logic [ADDR_W-1:0] r_addrb;
  logic [DATA_W-1:0] r_dinb;

  tag_t              r_tag_a [RD_LAT+1];
  tag_t              r_tag_b [RD_LAT+1];
  logic [NREQ-1:0]   w_hit_a;
  logic [NREQ-1:0]   w_hit_b;

  // Unpack the flat request buses
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_addr[i]  = req_addr[i*ADDR_W +: ADDR_W];
      w_wdata[i] = req_wdata[i*DATA_W +: DATA_W];
    end
  end

  // First two pending requesters starting at ptr become P (port A) and Q (port B)
  always_comb begin
    w_p_vld = 1'b0;
    w_q_vld = 1'b0;
    w_p_idx = '0;
    w_q_idx = '0;
    w_scan  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_scan = PTR_W'((32'(r_ptr) + k) % NREQ);
      if (req[w_scan]) begin
        if (!w_p_vld) begin
          w_p_vld = 1'b1;
          w_p_idx = w_scan;
        end else if (!w_q_vld) begin
          w_q_vld = 1'b1;
          w_q_idx = w_scan;
        end
      end
    end
  end

`ifdef BRAM_ARB_COLLISION_EN
  assign w_coll = w_p_vld && w_q_vld && (w_addr[w_p_idx] == w_addr[w_q_idx])
                  && (req_we[w_p_idx] || req_we[w_q_idx]);
`else
  assign w_coll = 1'b0;
`endif

  assign w_q_gnt   = w_q_vld && !w_coll;
  assign w_last    = w_q_gnt ? w_q_idx : w_p_idx;
  assign w_ptr_nxt = (32'(w_last) == NREQ - 1) ? '0 : w_last + PTR_W'(1);

  always_comb begin
    w_gnt = '0;
    if (w_p_vld) w_gnt[w_p_idx] = 1'b1;
    if (w_q_gnt) w_gnt[w_q_idx] = 1'b1;
  end

  assign gnt = rst_n ? w_gnt : '0;

  // Priority pointer and registered BRAM port commands; idle ports keep addr/din
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_ena   <= 1'b0;
      r_wea   <= 1'b0;
      r_addra <= '0;
      r_dina  <= '0;
      r_enb   <= 1'b0;
      r_web   <= 1'b0;
      r_addrb <= '0;
      r_dinb  <= '0;
    end else begin
      if (w_p_vld) r_ptr <= w_ptr_nxt;
      r_ena <= w_p_vld;
      r_wea <= w_p_vld && req_we[w_p_idx];
      if (w_p_vld) begin
        r_addra <= w_addr[w_p_idx];
        r_dina  <= w_wdata[w_p_idx];
      end
      r_enb <= w_q_gnt;
      r_web <= w_q_gnt && req_we[w_q_idx];
      if (w_q_gnt) begin
        r_addrb <= w_addr[w_q_idx];
        r_dinb  <= w_wdata[w_q_idx];
      end
    end
  end

  // Read tags ride alongside the BRAM latency so data returns to its owner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i <= RD_LAT; i++) begin
        r_tag_a[i] <= '0;
        r_tag_b[i] <= '0;
      end
    end else begin
      r_tag_a[0] <= tag_t'{vld: w_p_vld && !req_we[w_p_idx], idx: w_p_idx};
      r_tag_b[0] <= tag_t'{vld: w_q_gnt && !req_we[w_q_idx], idx: w_q_idx};
      for (int unsigned i = 1; i <= RD_LAT; i++) begin
        r_tag_a[i] <= r_tag_a[i-1];
        r_tag_b[i] <= r_tag_b[i-1];
      end
    end
  end

  always_comb begin
    w_hit_a = '0;
    w_hit_b = '0;
    w_hit_a[r_tag_a[RD_LAT].idx] = r_tag_a[RD_LAT].vld;
    w_hit_b[r_tag_b[RD_LAT].idx] = r_tag_b[RD_LAT].vld;
  end

  assign rvalid = w_hit_a | w_hit_b;

  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_hit_a[i])      rdata[i*DATA_W +: DATA_W] = douta;
      else if (w_hit_b[i]) rdata[i*DATA_W +: DATA_W] = doutb;
    end
  end

  assign ena   = r_ena;
  assign wea   = r_wea;
  assign addra = r_addra;
  assign dina  = r_dina;
  assign enb   = r_enb;
  assign web   = r_web;
  assign addrb = r_addrb;
  assign dinb  = r_dinb;

endmodule

// File: tb/tb_lvt_bram_arbiter.sv
// Bench for lvt_bram_arbiter: directed scenarios plus a read-return scoreboard against a
// write-first 16x32 dual-port BRAM model. Honours BRAM_ARB_COLLISION_EN when defined.
module tb_lvt_bram_arbiter;
  localparam int unsigned NREQ   = 4;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned RD_LAT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst_n;
  logic [NREQ-1:0]         req, req_we, gnt, rvalid;
  logic [NREQ*ADDR_W-1:0]  req_addr;
  logic [NREQ*DATA_W-1:0]  req_wdata, rdata;
  logic                    ena, wea, enb, web;
  logic [ADDR_W-1:0]       addra, addrb;
  logic [DATA_W-1:0]       dina, dinb, douta, doutb;

  lvt_bram_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb));

  function automatic logic [31:0] init_val(input int a);
    return (a == 3) ? 32'hDEAD_BEEF : 32'h1000_0000 + 32'(a) * 32'h0000_0101;
  endfunction

  // Memory model, reloaded with known contents while reset is held
  logic [31:0] mem [16];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int a = 0; a < 16; a++) mem[a] <= init_val(a);
      douta <= '0;
      doutb <= '0;
    end else begin
      if (ena) begin
        if (wea) begin mem[addra] <= dina; douta <= dina; end
        else douta <= mem[addra];
      end
      if (enb) begin
        if (web) begin mem[addrb] <= dinb; doutb <= dinb; end
        else doutb <= mem[addrb];
      end
    end
  end

  typedef struct {
    int unsigned idx;
    logic [31:0] data;
    int unsigned due;
    bit          chk;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] shadow [16];
  int unsigned cyc;
  int          errors;
  int          checks;
  int          pulses [NREQ];

  function automatic logic [ADDR_W-1:0] a_of(input int i);
    return req_addr[i*ADDR_W +: ADDR_W];
  endfunction

  // One call per cycle at the falling edge: retire due reads, then log accepted requests
  task automatic sb_step();
    logic [NREQ-1:0] exp_mask, acc;
    exp_t e;
    bit clash;
    cyc++;
    if (!rst_n) begin
      for (int a = 0; a < 16; a++) shadow[a] = init_val(a);
      sbq.delete();
      return;
    end
    exp_mask = '0;
    while (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      exp_mask[e.idx] = 1'b1;
      checks++;
      if (rvalid[e.idx] !== 1'b1 || (e.chk && rdata[e.idx*DATA_W +: DATA_W] !== e.data)) begin
        errors++;
        $display("FAIL sb_read req%0d cyc%0d: rvalid=%b rdata=%h, need rvalid=1 rdata=%h",
                 e.idx, cyc, rvalid[e.idx], rdata[e.idx*DATA_W +: DATA_W], e.data);
      end
    end
    checks++;
    if (rvalid !== exp_mask) begin
      errors++;
      $display("FAIL sb_rvalid cyc%0d: got %b, need %b", cyc, rvalid, exp_mask);
    end
    for (int i = 0; i < NREQ; i++) if (rvalid[i] === 1'b1) pulses[i]++;
    acc = req & gnt;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i] && !req_we[i]) begin
        clash = 1'b0;
        for (int j = 0; j < NREQ; j++)
          if (j != i && acc[j] && req_we[j] && a_of(j) == a_of(i)) clash = 1'b1;
        sbq.push_back('{idx: i, data: shadow[a_of(i)], due: cyc + 2, chk: !clash});
      end
    end
    for (int i = 0; i < NREQ; i++)
      if (acc[i] && req_we[i]) shadow[a_of(i)] = req_wdata[i*DATA_W +: DATA_W];
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    sb_step();
  endtask

  task automatic clear_req();
    req = '0; req_we = '0;
  endtask

  task automatic set_req(input int i, input bit we, input logic [ADDR_W-1:0] a, input logic [31:0] d);
    req[i] = 1'b1;
    req_we[i] = we;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic do_reset();
    next_cycle(); clear_req(); rst_n = 1'b0; sample();
    next_cycle(); sample();
    next_cycle(); rst_n = 1'b1; sample();
  endtask

  task automatic check_gnt(input string name, input logic [NREQ-1:0] need);
    checks++;
    if (gnt !== need) begin
      errors++;
      $display("FAIL %s: gnt=%b, need %b", name, gnt, need);
    end
  endtask

  task automatic test_reset();
    next_cycle(); rst_n = 1'b0; req = '1; req_we = '0; sample();
    checks++;
    if (gnt !== '0 || rvalid !== '0 || rdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b rvalid=%b rdata=%h, need all 0", gnt, rvalid, rdata);
    end
    checks++;
    if ({ena, wea, enb, web} !== 4'b0 || addra !== '0 || addrb !== '0 || dina !== '0 || dinb !== '0) begin
      errors++;
      $display("FAIL reset_pins: ena=%b wea=%b enb=%b web=%b addra=%h addrb=%h dina=%h dinb=%h, need all 0",
               ena, wea, enb, web, addra, addrb, dina, dinb);
    end
    next_cycle(); clear_req(); sample();
    next_cycle(); rst_n = 1'b1; sample();
  endtask

  task automatic test_single_read();
    do_reset();
    next_cycle(); set_req(1, 1'b0, 4'd3, 32'h0); sample();
    check_gnt("single_gnt", 4'b0010);
    next_cycle(); clear_req(); sample();
    checks++;
    if (ena !== 1'b1 || wea !== 1'b0 || addra !== 4'd3 || enb !== 1'b0) begin
      errors++;
      $display("FAIL single_pins: ena=%b wea=%b addra=%h enb=%b, need 1 0 3 0", ena, wea, addra, enb);
    end
    next_cycle(); sample();
    checks++;
    if (rvalid !== 4'b0010 || rdata[63:32] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_rdata: rvalid=%b rdata1=%h, need 0010 deadbeef", rvalid, rdata[63:32]);
    end
    next_cycle(); sample();
    checks++;
    if (rvalid !== 4'b0000) begin
      errors++;
      $display("FAIL single_once: rvalid=%b, need 0000", rvalid);
    end
  endtask

  task automatic test_dual_issue();
    do_reset();
    next_cycle(); set_req(0, 1'b1, 4'd2, 32'h11); set_req(2, 1'b0, 4'd5, 32'h0); sample();
    check_gnt("dual_gnt", 4'b0101);
    next_cycle(); clear_req(); sample();
    checks++;
    if (ena !== 1'b1 || wea !== 1'b1 || addra !== 4'd2 || dina !== 32'h11 ||
        enb !== 1'b1 || web !== 1'b0 || addrb !== 4'd5) begin
      errors++;
      $display("FAIL dual_pins: A en=%b we=%b a=%h d=%h B en=%b we=%b a=%h, need A 1 1 2 11 B 1 0 5",
               ena, wea, addra, dina, enb, web, addrb);
    end
    next_cycle(); sample();
    checks++;
    if (rvalid !== 4'b0100 || rdata[95:64] !== init_val(5)) begin
      errors++;
      $display("FAIL dual_rdata: rvalid=%b rdata2=%h, need 0100 %h", rvalid, rdata[95:64], init_val(5));
    end
    next_cycle(); sample();
  endtask

  task automatic test_fairness();
    do_reset();
    for (int i = 0; i < NREQ; i++) pulses[i] = 0;
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 4'(8 + i), 32'h0);
      sample();
      check_gnt($sformatf("fair_gnt%0d", k), (k % 2 == 0) ? 4'b0011 : 4'b1100);
      if (k > 0) begin
        checks++;
        if (addra !== ((k % 2 == 1) ? 4'd8 : 4'd10) || addrb !== ((k % 2 == 1) ? 4'd9 : 4'd11)) begin
          errors++;
          $display("FAIL fair_pins%0d: addra=%h addrb=%h", k, addra, addrb);
        end
      end
    end
    for (int k = 0; k < 3; k++) begin next_cycle(); clear_req(); sample(); end
    for (int i = 0; i < NREQ; i++) begin
      checks++;
      if (pulses[i] != 4) begin
        errors++;
        $display("FAIL fair_pulses req%0d: got %0d, need 4", i, pulses[i]);
      end
    end
  endtask

  task automatic test_collision();
    do_reset();
    next_cycle(); set_req(0, 1'b1, 4'd7, 32'hA5A5_A5A5); set_req(1, 1'b0, 4'd7, 32'h0); sample();
`ifdef BRAM_ARB_COLLISION_EN
    check_gnt("coll_gnt1", 4'b0001);
    next_cycle(); req[0] = 1'b0; sample();
    check_gnt("coll_gnt2", 4'b0010);
    next_cycle(); clear_req(); sample();
    next_cycle(); sample();
    checks++;
    if (rvalid !== 4'b0010 || rdata[63:32] !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL coll_rdata: rvalid=%b rdata1=%h, need 0010 a5a5a5a5", rvalid, rdata[63:32]);
    end
`else
    check_gnt("coll_gnt1", 4'b0011);
    next_cycle(); clear_req(); sample();
    checks++;
    if ({ena, wea, enb, web} !== 4'b1110 || addra !== 4'd7 || addrb !== 4'd7) begin
      errors++;
      $display("FAIL coll_pins: ena,wea,enb,web=%b addra=%h addrb=%h, need 1110 7 7",
               {ena, wea, enb, web}, addra, addrb);
    end
    next_cycle(); sample();
`endif
    next_cycle(); sample();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    next_cycle(); set_req(2, 1'b0, 4'd5, 32'h0); sample();
    check_gnt("mid_gnt", 4'b0100);
    next_cycle(); clear_req(); rst_n = 1'b0; sample();
    checks++;
    if (gnt !== '0 || rvalid !== '0 || rdata !== '0 || {ena, wea, enb, web} !== 4'b0 ||
        addra !== '0 || addrb !== '0 || dina !== '0 || dinb !== '0) begin
      errors++;
      $display("FAIL mid_reset_vals: gnt=%b rvalid=%b en/we=%b addra=%h addrb=%h", gnt, rvalid,
               {ena, wea, enb, web}, addra, addrb);
    end
    for (int k = 0; k < 2; k++) begin
      next_cycle(); if (k == 1) rst_n = 1'b1; sample();
      checks++;
      if (rvalid !== '0) begin
        errors++;
        $display("FAIL mid_no_rvalid%0d: rvalid=%b, need 0000", k, rvalid);
      end
    end
    next_cycle(); set_req(1, 1'b0, 4'd1, 32'h0); set_req(3, 1'b0, 4'd9, 32'h0); sample();
    check_gnt("mid_ptr_gnt", 4'b1010);
    next_cycle(); clear_req(); sample();
    checks++;
    if (addra !== 4'd1 || addrb !== 4'd9) begin
      errors++;
      $display("FAIL mid_ptr_pins: addra=%h addrb=%h, need 1 9", addra, addrb);
    end
    next_cycle(); sample();
    next_cycle(); sample();
  endtask

  task automatic test_withdraw();
    logic [NREQ-1:0] need_gnt [4];
    logic [ADDR_W-1:0] need_a [4], need_b [4];
    need_gnt = '{4'b0011, 4'b0101, 4'b0110, 4'b0011};
    need_a   = '{4'd0, 4'd0, 4'd2, 4'd1};
    need_b   = '{4'd0, 4'd1, 4'd0, 4'd2};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      clear_req();
      for (int i = 0; i < 3; i++) set_req(i, 1'b0, 4'(i), 32'h0);
      if (k == 0) set_req(3, 1'b0, 4'd15, 32'h0);
      sample();
      check_gnt($sformatf("wd_gnt%0d", k), need_gnt[k]);
      if (k > 0) begin
        checks++;
        if (addra !== need_a[k] || addrb !== need_b[k]) begin
          errors++;
          $display("FAIL wd_pins%0d: addra=%h addrb=%h, need %h %h", k, addra, addrb, need_a[k], need_b[k]);
        end
      end
    end
    next_cycle(); clear_req(); sample();
    checks++;
    if (ena !== 1'b1 || enb !== 1'b1 || addra !== 4'd0 || addrb !== 4'd1) begin
      errors++;
      $display("FAIL wd_last_pins: ena=%b enb=%b addra=%h addrb=%h, need 1 1 0 1", ena, enb, addra, addrb);
    end
    next_cycle(); sample();
    checks++;
    if (ena !== 1'b0 || enb !== 1'b0 || addra !== 4'd0 || addrb !== 4'd1) begin
      errors++;
      $display("FAIL wd_idle_hold: ena=%b enb=%b addra=%h addrb=%h, need 0 0 0 1", ena, enb, addra, addrb);
    end
    next_cycle(); sample();
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    cyc = 0; errors = 0; checks = 0;
    for (int i = 0; i < NREQ; i++) pulses[i] = 0;
    test_reset();
    test_single_read();
    test_dual_issue();
    test_fairness();
    test_collision();
    test_reset_midflight();
    test_withdraw();
    for (int k = 0; k < 3; k++) begin next_cycle(); sample(); end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d reads never returned, need 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
